// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP transmit path.
package ssp_pkg;

    localparam int SSP_DATA_W    = 8;
    localparam int SSP_FETCH_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        SHIFT = 2'd2
    } ssp_state_e;

endpackage

// File: rtl/ssp_tx_fetch.sv
// Tx FIFO fetch engine: issues one pop at a time and parks the returned
// byte in a one-entry holding register until the shift engine takes it.
module ssp_tx_fetch
    import ssp_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              load_i,
    output logic              pop_o,
    output logic [DATA_W-1:0] hold_o,
    output logic              hold_v_o,
    output logic              busy_o
);

    localparam logic [1:0] FETCH_LAT = 2'(SSP_FETCH_LAT);

    logic              pop_q, pop_d;
    logic [1:0]        fcnt_q, fcnt_d;
    logic              hold_v_q, hold_v_d;
    logic [DATA_W-1:0] hold_q;
    logic              fill;

    // Next-state: a nonzero fetch counter means a pop is in flight; the
    // byte is captured on the edge where the counter expires.
    always_comb begin
        pop_d    = 1'b0;
        fcnt_d   = fcnt_q;
        hold_v_d = hold_v_q;
        fill     = 1'b0;
        if (fcnt_q != 2'd0) begin
            fcnt_d = fcnt_q - 2'd1;
            if (fcnt_q == 2'd1) begin
                fill     = 1'b1;
                hold_v_d = 1'b1;
            end
        end else if (!hold_v_q && !fifo_empty_i) begin
            pop_d  = 1'b1;
            fcnt_d = FETCH_LAT;
        end
        // The shift engine only loads while hold_v is set, so this never
        // collides with a fill (fills only complete while hold_v is clear).
        if (load_i) begin
            hold_v_d = 1'b0;
        end
    end

    // Control state: pop pulse, fetch counter, hold-valid flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pop_q    <= 1'b0;
            fcnt_q   <= 2'd0;
            hold_v_q <= 1'b0;
        end else begin
            pop_q    <= pop_d;
            fcnt_q   <= fcnt_d;
            hold_v_q <= hold_v_d;
        end
    end

    // Holding register data; qualified by hold_v, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            hold_q <= rd_data_i;
        end
    end

    assign pop_o    = pop_q;
    assign hold_o   = hold_q;
    assign hold_v_o = hold_v_q;
    assign busy_o   = hold_v_q | (fcnt_q != 2'd0);

endmodule

// File: rtl/ssp_tx_serializer.sv
// SSP transmit back end: TI synchronous-serial frames, MSB first, bit clock
// PCLK/2. FSS overlaps the LSB slot when the next byte is already held,
// giving gap-free back-to-back frames.
module ssp_tx_serializer
    import ssp_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W,
    parameter int CNT_W  = 3
) (
    input  logic              PCLK,
    input  logic              CLEAR_B,
    input  logic [DATA_W-1:0] TxData,
    input  logic              fifo_empty,
    output logic              shf_read_ready,
    output logic              SSPTXD,
    output logic              SSPFSSOUT,
    output logic              SSPCLKOUT,
    output logic              SSPOE_B,
    output logic              tx_busy
);

    logic              clk_ph_q;
    ssp_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              txd_q, txd_d;
    logic              fss_q, fss_d;
    logic              oe_b_q, oe_b_d;
    logic              boundary;
    logic              load;
    logic [DATA_W-1:0] hold;
    logic              hold_v;
    logic              fetch_busy;

    ssp_tx_fetch #(.DATA_W(DATA_W)) u_fetch (
        .clk_i        (PCLK),
        .rst_ni       (CLEAR_B),
        .fifo_empty_i (fifo_empty),
        .rd_data_i    (TxData),
        .load_i       (load),
        .pop_o        (shf_read_ready),
        .hold_o       (hold),
        .hold_v_o     (hold_v),
        .busy_o       (fetch_busy)
    );

    // Bit slots start on the edge where SSPCLKOUT rises.
    assign boundary = ~clk_ph_q;

    // Free-running divide-by-two serial clock.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            clk_ph_q <= 1'b0;
        end else begin
            clk_ph_q <= ~clk_ph_q;
        end
    end

    // Shift FSM next-state: FSS slot, then DATA_W bits; a pending byte
    // raises FSS during the LSB so the next MSB follows without a gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        fss_d   = fss_q;
        oe_b_d  = oe_b_q;
        load    = 1'b0;
        if (boundary) begin
            unique case (state_q)
                IDLE: begin
                    if (hold_v) begin
                        fss_d   = 1'b1;
                        oe_b_d  = 1'b0;
                        shreg_d = hold;
                        load    = 1'b1;
                        state_d = FRAME;
                    end
                end
                FRAME: begin
                    fss_d   = 1'b0;
                    txd_d   = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        txd_d   = shreg_q[DATA_W-1];
                        shreg_d = shreg_q << 1;
                        cnt_d   = cnt_q - 1'b1;
                        if ((cnt_q == CNT_W'(1)) && hold_v) begin
                            fss_d = 1'b1;
                        end
                    end else if (fss_q) begin
                        fss_d   = 1'b0;
                        txd_d   = hold[DATA_W-1];
                        shreg_d = hold << 1;
                        load    = 1'b1;
                        cnt_d   = CNT_W'(DATA_W - 1);
                    end else begin
                        txd_d   = 1'b0;
                        oe_b_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Shift FSM control and pin registers.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            txd_q   <= 1'b0;
            fss_q   <= 1'b0;
            oe_b_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            fss_q   <= fss_d;
            oe_b_q  <= oe_b_d;
        end
    end

    // Shift register data; only meaningful while a frame is active.
    always_ff @(posedge PCLK) begin
        shreg_q <= shreg_d;
    end

    assign SSPTXD    = txd_q;
    assign SSPFSSOUT = fss_q;
    assign SSPCLKOUT = clk_ph_q;
    assign SSPOE_B   = oe_b_q;
    assign tx_busy   = (state_q != IDLE) | fetch_busy;

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Bench for ssp_tx_serializer: FIFO model with two-edge read latency, a pin
// decoder that rebuilds bytes from the serial stream, and scenario tasks.
module tb_ssp_tx_serializer;

    logic       PCLK    = 1'b0;
    logic       CLEAR_B = 1'b0;
    logic [7:0] TxData  = 8'h00;
    logic       fifo_empty;
    logic       shf_read_ready, SSPTXD, SSPFSSOUT, SSPCLKOUT, SSPOE_B, tx_busy;

    int vectors     = 0;
    int miscompares = 0;

    // FIFO model: tasks write entries, the negedge process pops them.
    logic [7:0] fifo_mem [0:255];
    int         wp = 0;
    int         rp = 0;
    bit         ovr_en  = 1'b0;
    bit         ovr_val = 1'b0;

    // Pin decoder state and records.
    int         pop_cnt   = 0;
    int         underflow = 0;
    int         proto_err = 0;
    int         slot_cnt  = 0;
    int         rx_cnt    = 0;
    int         bitcnt    = 0;
    logic [7:0] shbuf     = 8'h00;
    logic [7:0] rx_mem [0:255];
    bit         slot_oe  [0:8191];
    bit         slot_fss [0:8191];
    bit         slot_txd [0:8191];

    assign fifo_empty = ovr_en ? ovr_val : (wp == rp);

    always #5 PCLK = ~PCLK;

    ssp_tx_serializer dut (
        .PCLK           (PCLK),
        .CLEAR_B        (CLEAR_B),
        .TxData         (TxData),
        .fifo_empty     (fifo_empty),
        .shf_read_ready (shf_read_ready),
        .SSPTXD         (SSPTXD),
        .SSPFSSOUT      (SSPFSSOUT),
        .SSPCLKOUT      (SSPCLKOUT),
        .SSPOE_B        (SSPOE_B),
        .tx_busy        (tx_busy)
    );

    // FIFO read port and serial-stream decoder, sampled mid-cycle.
    always @(negedge PCLK) begin
        if (shf_read_ready) begin
            pop_cnt <= pop_cnt + 1;
            if (rp != wp) begin
                TxData <= fifo_mem[rp[7:0]];
                rp     <= rp + 1;
            end else begin
                underflow <= underflow + 1;
            end
        end
        if (!CLEAR_B) begin
            bitcnt <= 0;
        end else if (SSPCLKOUT) begin
            if (slot_cnt < 8192) begin
                slot_oe[slot_cnt]  <= SSPOE_B;
                slot_fss[slot_cnt] <= SSPFSSOUT;
                slot_txd[slot_cnt] <= SSPTXD;
            end
            slot_cnt <= slot_cnt + 1;
            if (bitcnt != 0) begin
                shbuf <= {shbuf[6:0], SSPTXD};
                if (SSPOE_B) proto_err <= proto_err + 1;
                if (bitcnt == 1) begin
                    rx_mem[rx_cnt[7:0]] <= {shbuf[6:0], SSPTXD};
                    rx_cnt <= rx_cnt + 1;
                end
            end else if (!SSPFSSOUT && (SSPOE_B !== 1'b1 || SSPTXD !== 1'b0)) begin
                proto_err <= proto_err + 1;
            end
            if (SSPFSSOUT) begin
                if (SSPOE_B || bitcnt > 1) proto_err <= proto_err + 1;
                bitcnt <= 8;
            end else if (bitcnt != 0) begin
                bitcnt <= bitcnt - 1;
            end
        end
    end

    task automatic step();
        @(negedge PCLK);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wp[7:0]] = b;
        wp = wp + 1;
    endtask

    task automatic wait_idle(output bit timeout);
        int quiet;
        quiet   = 0;
        timeout = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!tx_busy && wp == rp) quiet++;
            else quiet = 0;
            if (quiet >= 4) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] b;
        bit to;
        b = 8'($urandom);
        CLEAR_B = 1'b0;
        push(b);
        repeat (4) step();
        vectors++; if (shf_read_ready !== 1'b0) begin miscompares++; $display("FAIL rst_pop: got %b expected 0", shf_read_ready); end
        vectors++; if (SSPTXD !== 1'b0) begin miscompares++; $display("FAIL rst_txd: got %b expected 0", SSPTXD); end
        vectors++; if (SSPFSSOUT !== 1'b0) begin miscompares++; $display("FAIL rst_fss: got %b expected 0", SSPFSSOUT); end
        vectors++; if (SSPCLKOUT !== 1'b0) begin miscompares++; $display("FAIL rst_clk: got %b expected 0", SSPCLKOUT); end
        vectors++; if (SSPOE_B !== 1'b1) begin miscompares++; $display("FAIL rst_oe: got %b expected 1", SSPOE_B); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", tx_busy); end
        vectors++; if (pop_cnt != 0) begin miscompares++; $display("FAIL rst_popcnt: got %0d expected 0", pop_cnt); end
        CLEAR_B = 1'b1;
        step();
        vectors++; if (shf_read_ready !== 1'b1) begin miscompares++; $display("FAIL rel_pop: got %b expected 1", shf_read_ready); end
        step();
        vectors++; if (shf_read_ready !== 1'b0) begin miscompares++; $display("FAIL rel_pop_pulse: got %b expected 0", shf_read_ready); end
        wait_idle(to);
        vectors++; if (to) begin miscompares++; $display("FAIL rel_idle: got timeout expected idle"); end
        vectors++; if (rx_cnt != 1 || rx_mem[0] !== b) begin miscompares++; $display("FAIL rel_byte: got %0d bytes/%h expected 1/%h", rx_cnt, rx_mem[0], b); end
        vectors++; if (pop_cnt != 1) begin miscompares++; $display("FAIL rel_pops: got %0d expected 1", pop_cnt); end
    endtask

    task automatic test_single_a5();
        logic [7:0] b;
        int s0, r0, p0, f;
        bit to;
        b  = 8'hA5;
        s0 = slot_cnt; r0 = rx_cnt; p0 = pop_cnt; f = -1;
        push(b);
        wait_idle(to);
        vectors++; if (to) begin miscompares++; $display("FAIL a5_idle: got timeout expected idle"); end
        for (int i = s0; i < slot_cnt; i++) if (slot_fss[i]) begin f = i; break; end
        vectors++;
        if (f < 0) begin
            miscompares++; $display("FAIL a5_fss: got no FSS slot expected one");
        end else begin
            vectors++; if (slot_oe[f] !== 1'b0) begin miscompares++; $display("FAIL a5_fss_oe: got %b expected 0", slot_oe[f]); end
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if ({slot_oe[f+1+k], slot_fss[f+1+k], slot_txd[f+1+k]} !== {2'b00, b[7-k]}) begin
                    miscompares++;
                    $display("FAIL a5_bit%0d: got oe/fss/txd %b%b%b expected 00%b", k, slot_oe[f+1+k], slot_fss[f+1+k], slot_txd[f+1+k], b[7-k]);
                end
            end
            vectors++; if ({slot_oe[f+9], slot_txd[f+9]} !== 2'b10) begin miscompares++; $display("FAIL a5_end: got oe/txd %b%b expected 10", slot_oe[f+9], slot_txd[f+9]); end
        end
        vectors++; if (pop_cnt - p0 != 1) begin miscompares++; $display("FAIL a5_pops: got %0d expected 1", pop_cnt - p0); end
        vectors++; if (rx_cnt - r0 != 1 || rx_mem[r0[7:0]] !== b) begin miscompares++; $display("FAIL a5_rx: got %0d/%h expected 1/%h", rx_cnt - r0, rx_mem[r0[7:0]], b); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        int s0, r0, p0, f;
        bit to;
        w  = 16'h817E;
        s0 = slot_cnt; r0 = rx_cnt; p0 = pop_cnt; f = -1;
        push(w[15:8]); push(w[7:0]);
        wait_idle(to);
        vectors++; if (to) begin miscompares++; $display("FAIL b2b_idle: got timeout expected idle"); end
        for (int i = s0; i < slot_cnt; i++) if (slot_fss[i]) begin f = i; break; end
        vectors++;
        if (f < 0) begin
            miscompares++; $display("FAIL b2b_fss: got no FSS slot expected one");
        end else begin
            for (int k = 0; k < 16; k++) begin
                vectors++;
                if ({slot_oe[f+1+k], slot_fss[f+1+k], slot_txd[f+1+k]} !== {1'b0, (k == 7), w[15-k]}) begin
                    miscompares++;
                    $display("FAIL b2b_slot%0d: got oe/fss/txd %b%b%b expected 0%b%b", k, slot_oe[f+1+k], slot_fss[f+1+k], slot_txd[f+1+k], (k == 7), w[15-k]);
                end
            end
            vectors++; if ({slot_oe[f+17], slot_txd[f+17]} !== 2'b10) begin miscompares++; $display("FAIL b2b_end: got oe/txd %b%b expected 10", slot_oe[f+17], slot_txd[f+17]); end
        end
        vectors++; if (pop_cnt - p0 != 2) begin miscompares++; $display("FAIL b2b_pops: got %0d expected 2", pop_cnt - p0); end
        vectors++; if (rx_cnt - r0 != 2 || rx_mem[r0[7:0]] !== w[15:8] || rx_mem[8'(r0 + 1)] !== w[7:0]) begin
            miscompares++; $display("FAIL b2b_rx: got %0d %h %h expected 2 %h %h", rx_cnt - r0, rx_mem[r0[7:0]], rx_mem[8'(r0 + 1)], w[15:8], w[7:0]);
        end
    endtask

    task automatic test_empty_toggle();
        logic [7:0] b;
        int r0, p0, u0, n;
        bit to;
        b = 8'($urandom);
        r0 = rx_cnt; p0 = pop_cnt; u0 = underflow; n = 0;
        push(b);
        while (!shf_read_ready && n < 20) begin step(); n++; end
        vectors++; if (shf_read_ready !== 1'b1) begin miscompares++; $display("FAIL tog_pop: got %b expected 1", shf_read_ready); end
        ovr_val = 1'b0; ovr_en = 1'b1;
        step(); step();
        ovr_val = 1'b1;
        step();
        ovr_en = 1'b0;
        wait_idle(to);
        vectors++; if (to) begin miscompares++; $display("FAIL tog_idle: got timeout expected idle"); end
        vectors++; if (pop_cnt - p0 != 1) begin miscompares++; $display("FAIL tog_pops: got %0d expected 1", pop_cnt - p0); end
        vectors++; if (underflow != u0) begin miscompares++; $display("FAIL tog_underflow: got %0d expected %0d", underflow, u0); end
        vectors++; if (rx_cnt - r0 != 1 || rx_mem[r0[7:0]] !== b) begin miscompares++; $display("FAIL tog_rx: got %0d/%h expected 1/%h", rx_cnt - r0, rx_mem[r0[7:0]], b); end
    endtask

    task automatic test_async_reset();
        logic [7:0] b;
        int r0, p0, s0, n, bad;
        bit to;
        r0 = rx_cnt; p0 = pop_cnt; n = 0; bad = 0;
        push(8'hF0); push(8'($urandom));
        while (bitcnt != 4 && n < 200) begin step(); n++; end
        vectors++; if (bitcnt != 4) begin miscompares++; $display("FAIL abort_reach: got bitcnt %0d expected 4", bitcnt); end
        vectors++; if (pop_cnt - p0 != 2 || tx_busy !== 1'b1) begin miscompares++; $display("FAIL abort_held: got pops %0d busy %b expected 2 1", pop_cnt - p0, tx_busy); end
        #2;
        CLEAR_B = 1'b0;
        #1;
        vectors++;
        if ({shf_read_ready, SSPTXD, SSPFSSOUT, SSPCLKOUT, SSPOE_B, tx_busy} !== 6'b000010) begin
            miscompares++;
            $display("FAIL abort_outs: got pop/txd/fss/clk/oe/busy %b%b%b%b%b%b expected 000010", shf_read_ready, SSPTXD, SSPFSSOUT, SSPCLKOUT, SSPOE_B, tx_busy);
        end
        repeat (3) step();
        CLEAR_B = 1'b1;
        s0 = slot_cnt; p0 = pop_cnt;
        repeat (40) step();
        for (int i = s0; i < slot_cnt; i++) if (!slot_oe[i] || slot_fss[i] || slot_txd[i]) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL abort_quiet: got %0d active slots expected 0", bad); end
        vectors++; if (pop_cnt != p0) begin miscompares++; $display("FAIL abort_pops: got %0d expected 0", pop_cnt - p0); end
        vectors++; if (rx_cnt != r0) begin miscompares++; $display("FAIL abort_partial: got %0d bytes expected 0", rx_cnt - r0); end
        b = 8'h3C;
        push(b);
        wait_idle(to);
        vectors++; if (to || rx_cnt != r0 + 1 || rx_mem[r0[7:0]] !== b) begin
            miscompares++; $display("FAIL abort_resume: got %0d/%h expected 1/%h", rx_cnt - r0, rx_mem[r0[7:0]], b);
        end
    endtask

    task automatic test_pop_timing();
        logic [7:0] a, b, c;
        int r0, p0, n, ld, pp;
        bit prev, to;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        r0 = rx_cnt; p0 = pop_cnt; n = 0; ld = -1; pp = -1;
        push(a); push(b);
        while (bitcnt != 5 && n < 200) begin step(); n++; end
        vectors++; if (bitcnt != 5 || pop_cnt - p0 != 2) begin miscompares++; $display("FAIL pt_setup: got bitcnt %0d pops %0d expected 5 2", bitcnt, pop_cnt - p0); end
        push(c);
        prev = SSPFSSOUT;
        for (int k = 0; k < 60; k++) begin
            step();
            if (prev && !SSPFSSOUT && !SSPOE_B && ld < 0) ld = k;
            if (shf_read_ready && pp < 0) pp = k;
            prev = SSPFSSOUT;
        end
        vectors++; if (ld < 0) begin miscompares++; $display("FAIL pt_load: got no hold load expected one"); end
        vectors++; if (pp < ld || pp > ld + 1) begin miscompares++; $display("FAIL pt_pop: got pop step %0d expected %0d..%0d", pp, ld, ld + 1); end
        wait_idle(to);
        vectors++;
        if (to || rx_cnt - r0 != 3 || rx_mem[r0[7:0]] !== a || rx_mem[8'(r0 + 1)] !== b || rx_mem[8'(r0 + 2)] !== c) begin
            miscompares++;
            $display("FAIL pt_rx: got %0d %h %h %h expected 3 %h %h %h", rx_cnt - r0, rx_mem[r0[7:0]], rx_mem[8'(r0 + 1)], rx_mem[8'(r0 + 2)], a, b, c);
        end
        vectors++; if (pop_cnt - p0 != 3) begin miscompares++; $display("FAIL pt_pops: got %0d expected 3", pop_cnt - p0); end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_q [$];
        logic [7:0] b;
        int r0, p0, nb;
        bit to;
        r0 = rx_cnt; p0 = pop_cnt;
        nb = 10 + int'($urandom_range(0, 6));
        for (int i = 0; i < nb; i++) begin
            b = 8'($urandom);
            push(b);
            exp_q.push_back(b);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 40)) step();
        end
        wait_idle(to);
        vectors++; if (to || rx_cnt - r0 != nb) begin miscompares++; $display("FAIL rnd_count: got %0d expected %0d", rx_cnt - r0, nb); end
        for (int i = 0; i < nb; i++) begin
            vectors++;
            if (rx_mem[8'(r0 + i)] !== exp_q[i]) begin miscompares++; $display("FAIL rnd_byte%0d: got %h expected %h", i, rx_mem[8'(r0 + i)], exp_q[i]); end
        end
        vectors++; if (pop_cnt - p0 != nb) begin miscompares++; $display("FAIL rnd_pops: got %0d expected %0d", pop_cnt - p0, nb); end
        vectors++; if (proto_err != 0) begin miscompares++; $display("FAIL protocol: got %0d violations expected 0", proto_err); end
        vectors++; if (underflow != 0) begin miscompares++; $display("FAIL underflow: got %0d expected 0", underflow); end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_empty_toggle();
        test_async_reset();
        test_pop_timing();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
